lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Downstream consumer of the 4-bit LFSR generator; samples the generator's parallel state output every valid cycle.
- Self-synchronises to the sequence, declares lock, and flywheels a local predictor once locked.
- Flags mismatches and counts them; also flags the all-zero lockup state.
- Used as the on-chip/self-check stage behind the LFSR in the test and link-check paths.

Parameters:
- W, 4, LFSR state width (≥2).
- TAPS, 4'b1100, feedback mask; next(s) = {s[W-2:0], ^(s & TAPS)}; the default gives a maximal 15-state sequence.
- LOCK_CNT, 3, consecutive correct predictions required to enter LOCKED.
- UNLOCK_CNT, 4, consecutive mispredictions in LOCKED that force return to SEARCH.
- CNT_W, 16, error counter width.

Ports:
- clk  input  1  rising-edge clock
- RSTn  input  1  asynchronous active-low reset
- valid_i  input  1  data_i holds a new LFSR state this cycle
- data_i  input  W  LFSR state sample (connects to generator lfsr_o)
- clr_i  input  1  synchronous clear of err_cnt_o
- locked_o  output  1  checker locked to the sequence
- err_o  output  1  one-cycle pulse: locked-mode misprediction
- zero_o  output  1  one-cycle pulse: valid sample equal to all-zeros
- err_cnt_o  output  CNT_W  saturating count of err_o pulses

Behaviour:
- Reset (RSTn=0, async): state=SEARCH, ref=0, match/miss counters=0, locked_o=0, err_o=0, zero_o=0, err_cnt_o=0.
- All outputs are registered. Latency: response appears the cycle after the valid_i edge that presented the sample.
- valid_i=0: no state, ref or counter changes; err_o and zero_o return to 0.
- SEARCH state:
  - First valid sample after entering SEARCH loads ref=data_i with match count 0.
  - Each later valid sample: if data_i==next(ref), increment match; otherwise match=0.
  - ref<=data_i on every valid sample (re-seed).
  - On the sample making match==LOCK_CNT, go to LOCKED; locked_o=1 the next cycle.
  - err_o is never asserted in SEARCH.
- LOCKED state (flywheel):
  - Each valid sample: pred=next(ref); ref<=pred, never data_i.
  - data_i!=pred: err_o pulse, err_cnt_o+1, miss+1.
  - data_i==pred: miss=0.
  - When miss reaches UNLOCK_CNT, go to SEARCH; locked_o=0 the next cycle; the match counter is cleared.
- Zero sample: a valid data_i==0 pulses zero_o in any state. In SEARCH it also forces match=0 (0 is never accepted as a seed). In LOCKED it is a normal misprediction.
- err_cnt_o saturates at all-ones and does not wrap.
- clr_i clears err_cnt_o. clr_i coincident with an error: the result is 0 (clear wins).
- Simultaneous events:
  - The sample that reaches UNLOCK_CNT still pulses err_o and counts.
  - The sample that achieves lock is not checked for error.
- RSTn asserted mid-operation: immediate return to reset values; the full LOCK_CNT re-acquisition is required after release.

Decomposition:
- Package lfsr_pkg: state enum {SEARCH, LOCKED}, the default W/TAPS constants, and a function lfsr_next(s, taps) shared with the generator.
- One natural sub-module: lfsr_err_counter (saturating counter with synchronous clear).

Test Plan (defaults; sequence from 0001: 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, repeat):
- Reset then continuous valid samples from 0001 -> locked_o rises the cycle after sample 1001 (4th); err_cnt_o stays 0 for 40 samples.
- Locked; replace one sample 0110 with 0111 -> one err_o pulse the following cycle, err_cnt_o=1, locked_o stays 1, later samples match.
- Locked; feed 4 corrupted samples -> err_cnt_o=4, locked_o falls after the 4th; clean stream resumes -> relock after 4 valid samples.
- Drive data_i=0000 with valid_i=1 in SEARCH -> zero_o pulse, no lock; valid_i low for 5 cycles mid-stream while locked -> no errors.
- Force err_cnt_o to 16'hFFFE, inject 3 errors -> holds 16'hFFFF; assert clr_i together with an error -> 0.
- RSTn pulse low while locked -> locked_o, err_cnt_o go to 0 immediately (before the next clk edge).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the 4-bit generator and its checker.
//   lfsr_state_e : checker search/lock state
//   LFSR_W       : default state width
//   LFSR_TAPS    : default feedback mask, maximal 15-state sequence
//   lfsr_next()  : next-state function, width given at the call site
package lfsr_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  localparam int              LFSR_W    = 4;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
  localparam int              LFSR_MAX_W = 32;

  // Works on a zero-extended state so one function serves every width up
  // to LFSR_MAX_W; bits at and above w are masked off the result.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    w
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] fb;
    mask = (w >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
    fb   = LFSR_MAX_W'(^(s & taps & mask));
    return ((s << 1) | fb) & mask;
  endfunction

endpackage

// File: rtl/lfsr_err_counter.sv
// Saturating error counter with synchronous clear.
//   clk       : rising-edge clock
//   RSTn      : asynchronous active-low reset
//   clr       : synchronous clear, wins over inc
//   inc       : count one error this cycle
//   cnt       : current count, sticks at all-ones
module lfsr_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: self-synchronises to the generator's parallel
// state, then flywheels a local predictor and flags mispredictions.
//   clk       : rising-edge clock
//   RSTn      : asynchronous active-low reset
//   valid_i   : data_i carries a new LFSR state this cycle
//   data_i    : LFSR state sample
//   clr_i     : synchronous clear of err_cnt_o
//   locked_o  : checker locked to the sequence
//   err_o     : one-cycle pulse on a locked-mode misprediction
//   zero_o    : one-cycle pulse on a valid all-zero sample
//   err_cnt_o : saturating count of err_o pulses
//
// state  | meaning
// SEARCH | re-seeding ref from every sample, counting consecutive matches
// LOCKED | ref free-runs on its own prediction, counting consecutive misses
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int             W          = LFSR_W,
  parameter logic [W-1:0]   TAPS       = LFSR_TAPS,
  parameter int             LOCK_CNT   = 3,
  parameter int             UNLOCK_CNT = 4,
  parameter int             CNT_W      = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             valid_i,
  input  logic [W-1:0]     data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             zero_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(UNLOCK_CNT + 1);

  lfsr_state_e   state_q;
  logic [W-1:0]  ref_q;
  logic          seeded_q;
  logic [MW-1:0] match_q;
  logic [XW-1:0] miss_q;

  logic [W-1:0]  pred;
  logic [MW-1:0] match_nxt;
  logic [XW-1:0] miss_nxt;
  logic          err_event;
  logic          is_zero;

  always_comb begin
    pred      = W'(lfsr_next(LFSR_MAX_W'(ref_q), LFSR_MAX_W'(TAPS), W));
    match_nxt = match_q + MW'(1);
    miss_nxt  = miss_q + XW'(1);
    is_zero   = (data_i == '0);
    err_event = valid_i && (state_q == LOCKED) && (data_i != pred);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= SEARCH;
      ref_q    <= '0;
      seeded_q <= 1'b0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_o <= 1'b0;
      err_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      err_o  <= err_event;
      zero_o <= valid_i && is_zero;
      if (valid_i) begin
        case (state_q)
          SEARCH: begin
            ref_q    <= data_i;
            seeded_q <= 1'b1;
            // An unseeded ref, a zero sample or a wrong step all restart
            // the match run; the sample itself becomes the new seed.
            if (!seeded_q || is_zero || (data_i != pred)) begin
              match_q <= '0;
            end else if (match_nxt == MW'(LOCK_CNT)) begin
              state_q  <= LOCKED;
              locked_o <= 1'b1;
              match_q  <= '0;
              miss_q   <= '0;
            end else begin
              match_q <= match_nxt;
            end
          end
          LOCKED: begin
            ref_q <= pred;
            if (err_event) begin
              if (miss_nxt == XW'(UNLOCK_CNT)) begin
                state_q  <= SEARCH;
                locked_o <= 1'b0;
                match_q  <= '0;
                miss_q   <= '0;
                seeded_q <= 1'b0;
              end else begin
                miss_q <= miss_nxt;
              end
            end else begin
              miss_q <= '0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  lfsr_err_counter #(
    .CNT_W(CNT_W)
  ) u_err_counter (
    .clk (clk),
    .RSTn(RSTn),
    .clr (clr_i),
    .inc (err_event),
    .cnt (err_cnt_o)
  );

endmodule
